// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared widths, scan-chain layout, FSM states and AES round helpers
package aes_pkg;

   localparam int AES_KEY_W  = 256;
   localparam int AES_BLK_W  = 128;
   localparam int NR         = 14;
   localparam int SC_W       = 387;
   localparam int SC_PT_LSB  = 259;
   localparam int SC_KEY_LSB = 3;
   localparam int SC_PT_SEL  = 2;
   localparam int SC_KEY_SEL = 1;
   localparam int SC_CT_SEL  = 0;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_RUN,
      ST_DONE
   } wrap_state_e;

   // Entry 0 occupies the most significant byte.
   localparam logic [2047:0] SBOX_TBL = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   function automatic logic [7:0] sbox(input logic [7:0] b);
      return SBOX_TBL[{~b, 3'b000} +: 8];
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
   endfunction

   // State bytes are column-major, byte 0 in bits [127:120].
   function automatic logic [127:0] sub_shift(input logic [127:0] s);
      logic [127:0] r;
      r = '0;
      for (int c = 0; c < 4; c++) begin
         for (int row = 0; row < 4; row++) begin
            r[127-8*(4*c+row) -: 8] = sbox(s[127-8*(4*((c+row)%4)+row) -: 8]);
         end
      end
      return r;
   endfunction

   function automatic logic [31:0] mix_col(input logic [31:0] col);
      logic [7:0] a0, a1, a2, a3, t;
      a0 = col[31:24];
      a1 = col[23:16];
      a2 = col[15:8];
      a3 = col[7:0];
      t  = a0 ^ a1 ^ a2 ^ a3;
      return {a0 ^ t ^ xtime(a0 ^ a1), a1 ^ t ^ xtime(a1 ^ a2),
              a2 ^ t ^ xtime(a2 ^ a3), a3 ^ t ^ xtime(a3 ^ a0)};
   endfunction

   function automatic logic [127:0] mix_columns(input logic [127:0] s);
      return {mix_col(s[127:96]), mix_col(s[95:64]), mix_col(s[63:32]), mix_col(s[31:0])};
   endfunction

   function automatic logic [7:0] rcon(input logic [2:0] j);
      return 8'h01 << (j - 3'd1);
   endfunction

   // kw holds {rk[idx-2], rk[idx-1]}; returns rk[idx] of the AES-256 schedule.
   function automatic logic [127:0] next_round_key(input logic [255:0] kw, input logic [3:0] idx);
      logic [31:0] t, n0, n1, n2, n3;
      if (!idx[0]) begin
         t = sub_word({kw[23:0], kw[31:24]}) ^ {rcon(idx[3:1]), 24'h0};
      end else begin
         t = sub_word(kw[31:0]);
      end
      n0 = kw[255:224] ^ t;
      n1 = kw[223:192] ^ n0;
      n2 = kw[191:160] ^ n1;
      n3 = kw[159:128] ^ n2;
      return {n0, n1, n2, n3};
   endfunction

endpackage

// File: rtl/aes256_core.sv
// rtl/aes256_core.sv - iterative AES-256 encryptor, one round per clock, key schedule on the fly
module aes256_core
   import aes_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [AES_KEY_W-1:0] key,
   input  logic [AES_BLK_W-1:0] pt,
   output logic                 busy,
   output logic                 done,
   output logic [AES_BLK_W-1:0] ct
);

   logic [AES_BLK_W-1:0] st_q, st_d;
   logic [AES_BLK_W-1:0] sr, mc;
   logic [AES_KEY_W-1:0] kw_q, kw_d;
   logic [3:0]           rnd_q, rnd_d;
   logic                 busy_q, busy_d;
   logic                 last_rnd;

   assign last_rnd = busy_q && (rnd_q == 4'(NR));

   always_comb begin
      sr     = sub_shift(st_q);
      mc     = mix_columns(sr);
      st_d   = st_q;
      kw_d   = kw_q;
      rnd_d  = rnd_q;
      busy_d = busy_q;
      if (start) begin
         st_d   = pt ^ key[255:128];
         kw_d   = key;
         rnd_d  = 4'd1;
         busy_d = 1'b1;
      end else if (busy_q) begin
         // Low half of kw_q is always the key of the round being applied.
         st_d   = (last_rnd ? sr : mc) ^ kw_q[127:0];
         kw_d   = {kw_q[127:0], next_round_key(kw_q, rnd_q + 4'd1)};
         rnd_d  = rnd_q + 4'd1;
         busy_d = !last_rnd;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st_q   <= '0;
         kw_q   <= '0;
         rnd_q  <= '0;
         busy_q <= 1'b0;
      end else begin
         st_q   <= st_d;
         kw_q   <= kw_d;
         rnd_q  <= rnd_d;
         busy_q <= busy_d;
      end
   end

   assign busy = busy_q;
   assign done = last_rnd;
   assign ct   = st_q;

endmodule

// File: rtl/aes_if_wrapper.sv
// rtl/aes_if_wrapper.sv - scan-chain driven control wrapper: FSM, source muxes, counter, output registers
module aes_if_wrapper
   import aes_pkg::*;
#(
   parameter logic [AES_KEY_W-1:0] HARD_KEY = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
   parameter logic [AES_BLK_W-1:0] CTR_INIT = 128'h0
) (
   input  logic              CLK,
   input  logic              RST_N,
   input  logic [SC_W-1:0]   SCAN_CHAIN,
   input  logic              ENABLE,
   output logic              TRIGGER_EXT,
   output logic [SC_W-1:0]   CIPHERTEXT,
   output logic [AES_BLK_W-1:0] CT_OUT
);

   wrap_state_e          state_q;
   logic                 start_q, trig_q, pt_sel_q, ct_sel_q;
   logic [AES_KEY_W-1:0] key_q;
   logic [AES_BLK_W-1:0] pt_q, ctr_q, ct_q, ct_out_q;
   logic                 core_busy, core_done;
   logic [AES_BLK_W-1:0] core_ct;
   logic [AES_BLK_W-1:0] sc_pt;
   logic [AES_KEY_W-1:0] sc_key;

   assign sc_pt  = SCAN_CHAIN[SC_PT_LSB +: AES_BLK_W];
   assign sc_key = SCAN_CHAIN[SC_KEY_LSB +: AES_KEY_W];

   // Operands are captured on entry to LOAD so the core sees them stable while start is high.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q  <= ST_IDLE;
         start_q  <= 1'b0;
         trig_q   <= 1'b0;
         pt_sel_q <= 1'b0;
         ct_sel_q <= 1'b0;
         key_q    <= '0;
         pt_q     <= '0;
         ctr_q    <= CTR_INIT;
         ct_q     <= '0;
         ct_out_q <= '0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (ENABLE && !core_busy) begin
                  pt_sel_q <= SCAN_CHAIN[SC_PT_SEL];
                  ct_sel_q <= SCAN_CHAIN[SC_CT_SEL];
                  key_q    <= SCAN_CHAIN[SC_KEY_SEL] ? sc_key : HARD_KEY;
                  pt_q     <= SCAN_CHAIN[SC_PT_SEL] ? sc_pt : ctr_q;
                  start_q  <= 1'b1;
                  state_q  <= ST_LOAD;
               end
            end
            ST_LOAD: begin
               start_q <= 1'b0;
               trig_q  <= 1'b1;
               state_q <= ST_RUN;
            end
            ST_RUN: begin
               if (core_done) begin
                  trig_q  <= 1'b0;
                  state_q <= ST_DONE;
               end
            end
            ST_DONE: begin
               ct_q     <= core_ct;
               ct_out_q <= ct_sel_q ? core_ct : '0;
               if (!pt_sel_q) begin
                  ctr_q <= ctr_q + 128'd1;
               end
               state_q  <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   aes256_core u_core (
      .clk   (CLK),
      .rst_n (RST_N),
      .start (start_q),
      .key   (key_q),
      .pt    (pt_q),
      .busy  (core_busy),
      .done  (core_done),
      .ct    (core_ct)
   );

   assign TRIGGER_EXT = trig_q;
   assign CIPHERTEXT  = {{(SC_W-AES_BLK_W){1'b0}}, ct_q};
   assign CT_OUT      = ct_out_q;

endmodule

// File: tb/tb_aes_if_wrapper.sv
// tb/tb_aes_if_wrapper.sv - directed vector bench for aes_if_wrapper with a byte-level AES-256 reference
module tb_aes_if_wrapper;

   localparam logic [255:0] HARD_KEY  = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
   localparam logic [255:0] KEY_JUNK  = 256'h0123456789abcdeffedcba98765432100f1e2d3c4b5a69788796a5b4c3d2e1f0;
   localparam logic [127:0] FIPS_PT   = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] CT_FIPS   = 128'h8ea2b7ca516745bfeafc49904b496089;
   localparam logic [127:0] CT_K0     = 128'h1c060f4c9e7ea8d6ca961a2d64c05c18;
   localparam logic [127:0] CT_ZZ     = 128'hdc95c078a2408989ad48a21492842087;

   logic         CLK = 1'b0;
   logic         RST_N;
   logic [386:0] SCAN_CHAIN;
   logic         en_a, en_b;
   logic         trig_a, trig_b;
   logic [386:0] ciph_a, ciph_b;
   logic [127:0] ctout_a, ctout_b;

   always #5 CLK = ~CLK;

   aes_if_wrapper dut (
      .CLK(CLK), .RST_N(RST_N), .SCAN_CHAIN(SCAN_CHAIN), .ENABLE(en_a),
      .TRIGGER_EXT(trig_a), .CIPHERTEXT(ciph_a), .CT_OUT(ctout_a)
   );

   aes_if_wrapper #(.CTR_INIT({128{1'b1}})) dut_wrap (
      .CLK(CLK), .RST_N(RST_N), .SCAN_CHAIN(SCAN_CHAIN), .ENABLE(en_b),
      .TRIGGER_EXT(trig_b), .CIPHERTEXT(ciph_b), .CT_OUT(ctout_b)
   );

   typedef struct {
      logic [127:0] pt;
      logic [255:0] key;
      logic         pt_sel;
      logic         key_sel;
      logic         ct_sel;
      logic [127:0] exp_ct;
      logic [127:0] exp_ctout;
   } vec_t;

   vec_t       vecs[6];
   int         passed = 0;
   int         total  = 0;
   logic [7:0] sbox_m[256];

   task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
      total++;
      if (got === exp) passed++;
      else $display("FAIL %s: got %h expected %h", name, got, exp);
   endtask

   function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
      logic [7:0] a, b, p;
      a = a_in;
      b = b_in;
      p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p = p ^ a;
         a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
         b = b >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
      return (v << n) | (v >> (8 - n));
   endfunction

   function automatic logic [31:0] subw_m(input logic [31:0] w);
      return {sbox_m[w[31:24]], sbox_m[w[23:16]], sbox_m[w[15:8]], sbox_m[w[7:0]]};
   endfunction

   function automatic logic [127:0] aes_model(input logic [255:0] key, input logic [127:0] pt);
      logic [7:0]   s[16];
      logic [7:0]   t[16];
      logic [31:0]  w[60];
      logic [31:0]  tw;
      logic [7:0]   rc, a0, a1, a2, a3;
      logic [127:0] res;
      for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8];
      for (int i = 0; i < 8; i++) w[i] = key[255-32*i -: 32];
      rc = 8'h01;
      for (int i = 8; i < 60; i++) begin
         tw = w[i-1];
         if (i % 8 == 0) begin
            tw = subw_m({tw[23:0], tw[31:24]});
            tw[31:24] = tw[31:24] ^ rc;
            rc = gmul(rc, 8'h02);
         end else if (i % 8 == 4) begin
            tw = subw_m(tw);
         end
         w[i] = w[i-8] ^ tw;
      end
      for (int r = 0; r <= 14; r++) begin
         if (r > 0) begin
            for (int i = 0; i < 16; i++) t[i] = sbox_m[s[i]];
            for (int c = 0; c < 4; c++)
               for (int j = 0; j < 4; j++) s[4*c+j] = t[4*((c+j)%4)+j];
            if (r < 14) begin
               for (int c = 0; c < 4; c++) begin
                  a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
                  s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
                  s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
                  s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
                  s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
               end
            end
         end
         for (int c = 0; c < 4; c++)
            for (int j = 0; j < 4; j++) s[4*c+j] = s[4*c+j] ^ w[4*r+c][31-8*j -: 8];
      end
      res = '0;
      for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
      return res;
   endfunction

   function automatic logic [386:0] mk_sc(input logic [127:0] pt, input logic [255:0] key,
                                          input logic ps, input logic ks, input logic cs);
      return {pt, key, ps, ks, cs};
   endfunction

   task automatic do_reset();
      @(negedge CLK);
      RST_N = 1'b0;
      @(negedge CLK);
      RST_N = 1'b1;
   endtask

   // One request; returns with outputs of the finished encryption visible.
   task automatic do_enc(input bit b, input logic [386:0] sc, output int width);
      int n;
      @(negedge CLK);
      SCAN_CHAIN = sc;
      if (b) en_b = 1'b1;
      else en_a = 1'b1;
      @(negedge CLK);
      en_a = 1'b0;
      en_b = 1'b0;
      @(negedge CLK);
      SCAN_CHAIN = ~sc;
      width = 0;
      n = 0;
      while ((b ? trig_b : trig_a) && n < 40) begin
         width++;
         @(negedge CLK);
         n++;
      end
      @(negedge CLK);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int           w;
      int           hi;
      bit           prev;
      int           rises[$];
      int           widths[$];
      logic [127:0] r1, exp0, exp1;

      for (int x = 0; x < 256; x++) begin
         logic [7:0] inv;
         inv = 8'h00;
         for (int c = 1; c < 256; c++)
            if (gmul(8'(x), 8'(c)) == 8'h01) inv = 8'(c);
         sbox_m[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      end

      vecs[0] = '{FIPS_PT, KEY_JUNK, 1'b1, 1'b0, 1'b1, CT_FIPS, CT_FIPS};
      vecs[1] = '{FIPS_PT, KEY_JUNK, 1'b1, 1'b0, 1'b0, CT_FIPS, 128'h0};
      vecs[2] = '{FIPS_PT, 256'h0,   1'b1, 1'b1, 1'b1, CT_K0,   CT_K0};
      vecs[3] = '{FIPS_PT, 256'h0,   1'b1, 1'b1, 1'b0, CT_K0,   128'h0};
      vecs[4] = '{FIPS_PT, HARD_KEY, 1'b1, 1'b1, 1'b1, CT_FIPS, CT_FIPS};
      vecs[5] = '{128'h0,  256'h0,   1'b1, 1'b1, 1'b1, CT_ZZ,   CT_ZZ};

      RST_N = 1'b0;
      en_a = 1'b0;
      en_b = 1'b0;
      SCAN_CHAIN = '0;
      repeat (3) @(negedge CLK);
      check("rst_trigger", 128'(trig_a), 128'd0);
      check("rst_ciphertext", ciph_a[127:0], 128'h0);
      check("rst_ct_out", ctout_a, 128'h0);
      RST_N = 1'b1;

      for (int i = 0; i < 6; i++) begin
         do_enc(1'b0, mk_sc(vecs[i].pt, vecs[i].key, vecs[i].pt_sel, vecs[i].key_sel, vecs[i].ct_sel), w);
         check($sformatf("vec%0d_trig_width", i), 128'(w), 128'd14);
         check($sformatf("vec%0d_ciphertext", i), ciph_a[127:0], vecs[i].exp_ct);
         check($sformatf("vec%0d_ct_out", i), ctout_a, vecs[i].exp_ctout);
         check($sformatf("vec%0d_upper_zero", i), 128'(ciph_a[386:128] != '0), 128'd0);
      end

      exp0 = aes_model(HARD_KEY, 128'h0);
      exp1 = aes_model(HARD_KEY, 128'h1);
      do_reset();
      do_enc(1'b0, mk_sc(~FIPS_PT, KEY_JUNK, 1'b0, 1'b0, 1'b1), w);
      check("ctr0_ciphertext", ciph_a[127:0], exp0);
      r1 = ciph_a[127:0];
      do_enc(1'b0, mk_sc(~FIPS_PT, KEY_JUNK, 1'b0, 1'b0, 1'b1), w);
      check("ctr1_ciphertext", ciph_a[127:0], exp1);
      check("ctr_runs_differ", 128'(r1 != ciph_a[127:0]), 128'd1);
      do_reset();
      do_enc(1'b0, mk_sc(FIPS_PT, KEY_JUNK, 1'b0, 1'b0, 1'b0), w);
      check("ctr_rereset_ciphertext", ciph_a[127:0], exp0);
      check("ctr_rereset_ct_out", ctout_a, 128'h0);

      do_reset();
      SCAN_CHAIN = mk_sc(FIPS_PT, KEY_JUNK, 1'b1, 1'b0, 1'b1);
      @(negedge CLK);
      en_a = 1'b1;
      prev = 1'b0;
      hi = 0;
      for (int cyc = 0; cyc < 100; cyc++) begin
         @(negedge CLK);
         if (trig_a && !prev) rises.push_back(cyc);
         if (trig_a) hi++;
         else if (prev) begin
            widths.push_back(hi);
            hi = 0;
         end
         prev = trig_a;
      end
      check("hold_rise_count", 128'(rises.size()), 128'd6);
      if (rises.size() > 0) check("hold_first_rise", 128'(rises[0]), 128'd1);
      for (int k = 0; k < widths.size(); k++)
         check($sformatf("hold_width%0d", k), 128'(widths[k]), 128'd14);
      for (int k = 1; k < rises.size(); k++)
         check($sformatf("hold_period%0d", k), 128'(rises[k] - rises[k-1]), 128'd17);
      check("hold_ciphertext", ciph_a[127:0], CT_FIPS);
      check("hold_ct_out", ctout_a, CT_FIPS);
      check("hold_in_run", 128'(trig_a), 128'd1);
      #2;
      RST_N = 1'b0;
      #1;
      check("abort_trigger", 128'(trig_a), 128'd0);
      check("abort_ciphertext", ciph_a[127:0], 128'h0);
      check("abort_ct_out", ctout_a, 128'h0);
      en_a = 1'b0;
      @(negedge CLK);
      RST_N = 1'b1;

      do_enc(1'b1, mk_sc(FIPS_PT, KEY_JUNK, 1'b0, 1'b0, 1'b1), w);
      check("wrap_first_ct", ctout_b, aes_model(HARD_KEY, {128{1'b1}}));
      do_enc(1'b1, mk_sc(FIPS_PT, KEY_JUNK, 1'b0, 1'b0, 1'b1), w);
      check("wrap_second_ct", ctout_b, exp0);
      check("wrap_ciphertext", ciph_b[127:0], exp0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
